// File: rtl/float_to_int_stream.sv
// IEEE-754 single to 25-bit signed integer converter with valid/ready handshakes.
// Iterative right shift of the mantissa, round half away from zero, saturating.
module float_to_int_stream #(
    parameter int SHIFTS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [24:0] out_data,
    output logic               out_sat,
    output logic               out_nan
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

    localparam logic [4:0] LP_S = 5'(SHIFTS_PER_CYCLE);

    state_t      r_state, w_next;
    logic [23:0] r_mag;
    logic        r_g, r_sign, r_sat, r_nan, r_zero;
    logic [4:0]  r_rem;

    logic [7:0]  w_exp;
    logic        w_frac_nz, w_is_nan, w_is_big, w_is_zero, w_direct, w_acc, w_guard;
    logic [4:0]  w_n, w_k, w_km1;

    function automatic logic signed [24:0] f_round(input logic sign, input logic [23:0] m,
                                                   input logic g, input logic sat,
                                                   input logic nan, input logic zero);
        logic [23:0]        mag;
        logic signed [24:0] val;
        if (nan || zero) begin
            f_round = '0;
        end else if (sat) begin
            f_round = sign ? 25'sh1000001 : 25'sh0FFFFFF;
        end else begin
            // Guard cannot carry out: a set guard implies at least one shift happened.
            mag     = m + {23'd0, g};
            val     = $signed({1'b0, mag});
            f_round = sign ? -val : val;
        end
    endfunction

    assign w_exp     = in_data[30:23];
    assign w_frac_nz = |in_data[22:0];
    assign w_is_nan  = (w_exp == 8'd255) && w_frac_nz;
    assign w_is_big  = (w_exp >= 8'd151);
    assign w_is_zero = (w_exp <= 8'd125);
    assign w_n       = 5'(8'd150 - w_exp);
    assign w_direct  = w_is_nan || w_is_big || w_is_zero || (w_exp == 8'd150);
    assign in_ready  = (r_state == S_IDLE);
    assign w_acc     = in_valid && in_ready;

    assign w_k       = (r_rem < LP_S) ? r_rem : LP_S;
    assign w_km1     = w_k - 5'd1;
    assign w_guard   = r_mag[w_km1];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_direct ? S_ROUND : S_SHIFT;
            S_SHIFT: if (r_rem <= LP_S) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_nan   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_mag  <= {1'b1, in_data[22:0]};
                        r_g    <= 1'b0;
                        r_sign <= in_data[31];
                        r_nan  <= w_is_nan;
                        r_sat  <= w_is_big && !w_is_nan;
                        r_zero <= w_is_zero;
                        r_rem  <= w_n;
                    end
                end
                S_SHIFT: begin
                    r_mag <= r_mag >> w_k;
                    r_g   <= w_guard;
                    r_rem <= r_rem - w_k;
                end
                S_ROUND: begin
                    out_valid <= 1'b1;
                    out_data  <= f_round(r_sign, r_mag, r_g, r_sat, r_nan, r_zero);
                    out_sat   <= r_sat;
                    out_nan   <= r_nan;
                end
                S_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
